// File: rtl/convnn_inter_pkg.sv
// Shared definitions for the inter-layer bank ring: layer FSM encoding,
// pointer wrap helper and the default ring depth.
package convnn_inter_pkg;

   localparam int DEFAULT_NUM_BANKS = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      FULL  = 2'd3
   } layer_state_t;

   function automatic int ptr_wrap(input int ptr, input int num_banks);
      return (ptr >= num_banks - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/inter_bank_router.sv
// Combinational per-bank demux of the two layers' RAM ports onto the ring,
// plus the q mux that returns the read bank's data to the next layer.
module inter_bank_router #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_W     = 224,
   parameter int NUM_BANKS  = 2,
   parameter int PTR_W      = 3
) (
   input  logic [PTR_W-1:0]                wr_ptr,
   input  logic [PTR_W-1:0]                rd_ptr,
   input  logic                            wr_active,
   input  logic                            rd_active,
   input  logic [ADDR_WIDTH-1:0]           former_addr_a,
   input  logic [ADDR_WIDTH-1:0]           former_addr_b,
   input  logic                            former_rden_a,
   input  logic                            former_rden_b,
   input  logic                            former_wren_a,
   input  logic                            former_wren_b,
   input  logic [ADDR_WIDTH-1:0]           next_addr_a,
   input  logic [ADDR_WIDTH-1:0]           next_addr_b,
   input  logic                            next_rden_a,
   input  logic                            next_rden_b,
   input  logic                            next_wren_a,
   input  logic                            next_wren_b,
   output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_a,
   output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_b,
   output logic [NUM_BANKS-1:0]            bank_rden_a,
   output logic [NUM_BANKS-1:0]            bank_rden_b,
   output logic [NUM_BANKS-1:0]            bank_wren_a,
   output logic [NUM_BANKS-1:0]            bank_wren_b,
   input  logic [NUM_BANKS*DATA_W-1:0]     bank_q_a_all,
   input  logic [NUM_BANKS*DATA_W-1:0]     bank_q_b_all,
   output logic [DATA_W-1:0]               next_q_a,
   output logic [DATA_W-1:0]               next_q_b
);

   // Write side wins the priority only nominally: the controller never lets
   // both active pointers land on the same bank.
   always_comb begin
      bank_addr_a = '0;
      bank_addr_b = '0;
      bank_rden_a = '0;
      bank_rden_b = '0;
      bank_wren_a = '0;
      bank_wren_b = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (wr_active && (wr_ptr == PTR_W'(i))) begin
            bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = former_addr_a;
            bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = former_addr_b;
            bank_rden_a[i] = former_rden_a;
            bank_rden_b[i] = former_rden_b;
            bank_wren_a[i] = former_wren_a;
            bank_wren_b[i] = former_wren_b;
         end else if (rd_active && (rd_ptr == PTR_W'(i))) begin
            bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = next_addr_a;
            bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = next_addr_b;
            bank_rden_a[i] = next_rden_a;
            bank_rden_b[i] = next_rden_b;
            bank_wren_a[i] = next_wren_a;
            bank_wren_b[i] = next_wren_b;
         end
      end
   end

   always_comb begin
      next_q_a = '0;
      next_q_b = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (rd_ptr == PTR_W'(i)) begin
            next_q_a = bank_q_a_all[i*DATA_W +: DATA_W];
            next_q_b = bank_q_b_all[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/layer_inter_ring_control.sv
// N-bank ring controller between two CNN layer engines. Optional statistics
// outputs (stall_cycles, max_occupancy) are built when INTER_RING_STATS_EN is defined.
//
// state | meaning
// IDLE  | layer parked, waiting for run and a bank to work on
// START | one-cycle restart pulse issued to the layer
// RUN   | layer enabled on its current bank
// FULL  | former only: every bank holds an unread frame
module layer_inter_ring_control
   import convnn_inter_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_W     = 224,
   parameter int NUM_BANKS  = DEFAULT_NUM_BANKS,
   parameter int PTR_W      = 3,
   parameter int CNT_W      = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            former_done,
   input  logic                            next_done,
   output logic                            former_enable,
   output logic                            former_reset,
   output logic                            next_enable,
   output logic                            next_reset,
   input  logic [ADDR_WIDTH-1:0]           former_addr_a,
   input  logic [ADDR_WIDTH-1:0]           former_addr_b,
   input  logic                            former_rden_a,
   input  logic                            former_rden_b,
   input  logic                            former_wren_a,
   input  logic                            former_wren_b,
   input  logic [ADDR_WIDTH-1:0]           next_addr_a,
   input  logic [ADDR_WIDTH-1:0]           next_addr_b,
   input  logic                            next_rden_a,
   input  logic                            next_rden_b,
   input  logic                            next_wren_a,
   input  logic                            next_wren_b,
   output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_a,
   output logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_b,
   output logic [NUM_BANKS-1:0]            bank_rden_a,
   output logic [NUM_BANKS-1:0]            bank_rden_b,
   output logic [NUM_BANKS-1:0]            bank_wren_a,
   output logic [NUM_BANKS-1:0]            bank_wren_b,
   input  logic [NUM_BANKS*DATA_W-1:0]     bank_q_a_all,
   input  logic [NUM_BANKS*DATA_W-1:0]     bank_q_b_all,
   output logic [DATA_W-1:0]               next_q_a,
   output logic [DATA_W-1:0]               next_q_b,
`ifdef INTER_RING_STATS_EN
   output logic [15:0]                     stall_cycles,
   output logic [CNT_W-1:0]                max_occupancy,
`endif
   output logic [CNT_W-1:0]                occupancy
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);

   layer_state_t       f_state;
   layer_state_t       n_state;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   occ_q;
   logic [CNT_W-1:0]   occ_next;
   logic               fd_acc;
   logic               nd_acc;

   // A done pulse only counts while its layer actually owns a bank.
   always_comb begin
      fd_acc   = former_done && (f_state == RUN);
      nd_acc   = next_done && (n_state == RUN);
      occ_next = occ_q;
      if (fd_acc && !nd_acc) begin
         occ_next = occ_q + CNT_W'(1);
      end else if (nd_acc && !fd_acc) begin
         occ_next = occ_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         occ_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         occ_q <= occ_next;
         if (fd_acc) wr_ptr <= PTR_W'(ptr_wrap(int'(wr_ptr), NUM_BANKS));
         if (nd_acc) rd_ptr <= PTR_W'(ptr_wrap(int'(rd_ptr), NUM_BANKS));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         f_state      <= IDLE;
         former_reset <= 1'b0;
      end else begin
         former_reset <= 1'b0;
         case (f_state)
            IDLE, FULL: begin
               if (enable && (occ_q < FULL_CNT)) begin
                  f_state      <= START;
                  former_reset <= 1'b1;
               end
            end
            START: begin
               if (enable) f_state <= RUN;
            end
            RUN: begin
               // A frame finishing while paused parks in IDLE so no restart fires until run returns.
               if (fd_acc) begin
                  if (occ_next == FULL_CNT) begin
                     f_state <= FULL;
                  end else if (enable) begin
                     f_state      <= START;
                     former_reset <= 1'b1;
                  end else begin
                     f_state <= IDLE;
                  end
               end
            end
            default: f_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         n_state    <= IDLE;
         next_reset <= 1'b0;
      end else begin
         next_reset <= 1'b0;
         case (n_state)
            IDLE: begin
               if (enable && (occ_q != '0)) begin
                  n_state    <= START;
                  next_reset <= 1'b1;
               end
            end
            START: begin
               if (enable) n_state <= RUN;
            end
            RUN: begin
               if (nd_acc) begin
                  if ((occ_next != '0) && enable) begin
                     n_state    <= START;
                     next_reset <= 1'b1;
                  end else begin
                     n_state <= IDLE;
                  end
               end
            end
            default: n_state <= IDLE;
         endcase
      end
   end

   assign former_enable = (f_state == RUN) && enable;
   assign next_enable   = (n_state == RUN) && enable;
   assign occupancy     = occ_q;

   inter_bank_router #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_W     (DATA_W),
      .NUM_BANKS  (NUM_BANKS),
      .PTR_W      (PTR_W)
   ) u_router (
      .wr_ptr        (wr_ptr),
      .rd_ptr        (rd_ptr),
      .wr_active     (f_state == RUN),
      .rd_active     (n_state == RUN),
      .former_addr_a (former_addr_a),
      .former_addr_b (former_addr_b),
      .former_rden_a (former_rden_a),
      .former_rden_b (former_rden_b),
      .former_wren_a (former_wren_a),
      .former_wren_b (former_wren_b),
      .next_addr_a   (next_addr_a),
      .next_addr_b   (next_addr_b),
      .next_rden_a   (next_rden_a),
      .next_rden_b   (next_rden_b),
      .next_wren_a   (next_wren_a),
      .next_wren_b   (next_wren_b),
      .bank_addr_a   (bank_addr_a),
      .bank_addr_b   (bank_addr_b),
      .bank_rden_a   (bank_rden_a),
      .bank_rden_b   (bank_rden_b),
      .bank_wren_a   (bank_wren_a),
      .bank_wren_b   (bank_wren_b),
      .bank_q_a_all  (bank_q_a_all),
      .bank_q_b_all  (bank_q_b_all),
      .next_q_a      (next_q_a),
      .next_q_b      (next_q_b)
   );

`ifdef INTER_RING_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles  <= '0;
         max_occupancy <= '0;
      end else begin
         if ((f_state == FULL) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (occ_next > max_occupancy) max_occupancy <= occ_next;
      end
   end
`endif

   occ_bound: assert property (@(posedge clock) disable iff (!reset) occ_q <= FULL_CNT);

endmodule
